// File: rtl/child_validator_array.sv
// child_validator_array: filters a batch of expanded children against the open/closed lists
// and streams the survivors out lowest slot first.
module child_validator_array #(
    parameter int NUM_CHILDREN = 8,
    parameter int G_W = 12,
    parameter int ID_W = 16,
    parameter bit ALLOW_EQUAL = 1'b0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_CHILDREN-1:0]              children_v,
    input  logic [NUM_CHILDREN*G_W-1:0]          children_g,
    input  logic [NUM_CHILDREN*ID_W-1:0]         children_id,
    input  logic [NUM_CHILDREN-1:0]              open_list,
    input  logic [NUM_CHILDREN-1:0]              close_list,
    input  logic [NUM_CHILDREN*G_W-1:0]          open_list_g_int,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ID_W-1:0]                      out_id,
    output logic [G_W-1:0]                       out_g,
    output logic                                 out_last,
    output logic                                 batch_done,
    output logic [$clog2(NUM_CHILDREN+1)-1:0]    batch_count
);
    localparam int CW = $clog2(NUM_CHILDREN + 1);
    localparam logic [1:0] IDLE = 2'd0, EVAL = 2'd1, EMIT = 2'd2;
    logic [1:0] state_q, state_d;
    logic [NUM_CHILDREN-1:0] v_q, op_q, cl_q, mask_q, mask_d, mask_eval, mask_rest;
    logic [NUM_CHILDREN*G_W-1:0] g_q, og_q;
    logic [NUM_CHILDREN*ID_W-1:0] id_q;
    logic [CW-1:0] cnt_q, cnt_d, pop;
    logic done_q, done_d, take_in, take_out;
    logic [ID_W-1:0] sel_id;
    logic [G_W-1:0] sel_g;
    always_comb begin
        take_in = in_valid && state_q == IDLE;
        take_out = out_ready && state_q == EMIT;
        mask_rest = mask_q & (mask_q - NUM_CHILDREN'(1));
        mask_eval = '0;
        pop = '0;
        sel_id = '0;
        sel_g = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            mask_eval[k] = v_q[k] & ~cl_q[k] & (~op_q[k] | (ALLOW_EQUAL ?
                g_q[k*G_W +: G_W] <= og_q[k*G_W +: G_W] : g_q[k*G_W +: G_W] < og_q[k*G_W +: G_W]));
            pop = pop + CW'(mask_eval[k]);
        end
        // descending scan so the lowest set slot wins
        for (int k = NUM_CHILDREN - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                sel_id = id_q[k*ID_W +: ID_W];
                sel_g = g_q[k*G_W +: G_W];
            end
        end
        state_d = state_q == IDLE ? (take_in ? EVAL : IDLE) :
                  state_q == EVAL ? (|mask_eval ? EMIT : IDLE) :
                  state_q == EMIT ? (take_out && mask_rest == '0 ? IDLE : EMIT) : IDLE;
        mask_d = state_q == EVAL ? mask_eval : take_out ? mask_rest : mask_q;
        cnt_d = state_q == EVAL ? pop : cnt_q;
        done_d = (state_q == EVAL && mask_eval == '0) || (take_out && mask_rest == '0);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
            v_q <= '0;
            op_q <= '0;
            cl_q <= '0;
            g_q <= '0;
            og_q <= '0;
            id_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q <= mask_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            if (take_in) begin
                v_q <= children_v;
                op_q <= open_list;
                cl_q <= close_list;
                g_q <= children_g;
                og_q <= open_list_g_int;
                id_q <= children_id;
            end
        end
    end
    assign in_ready = !reset && state_q == IDLE;
    assign out_valid = !reset && state_q == EMIT;
    assign out_last = out_valid && mask_rest == '0;
    assign out_id = out_valid ? sel_id : '0;
    assign out_g = out_valid ? sel_g : '0;
    assign batch_done = !reset && done_q;
    assign batch_count = reset ? '0 : cnt_q;
endmodule

// File: tb/tb_child_validator_array.sv
// tb_child_validator_array: randomized and directed checks of child_validator_array
// against a slot-list reference model, for ALLOW_EQUAL = 0 and 1.
module tb_child_validator_array;
    logic clock = 1'b0;
    logic reset, in_valid, out_ready;
    logic [7:0] children_v, open_list, close_list;
    logic [95:0] children_g, open_list_g_int;
    logic [127:0] children_id;
    logic ir0, ir1, ov0, ov1, ol0, ol1, bd0, bd1;
    logic [15:0] oid0, oid1;
    logic [11:0] og0, og1;
    logic [3:0] bc0, bc1;
    bit sel_dut = 1'b0;
    int tests = 0;
    int fails = 0;
    logic in_ready, out_valid, out_last, batch_done;
    logic [15:0] out_id;
    logic [11:0] out_g;
    logic [3:0] batch_count;

    always #5 clock = ~clock;

    child_validator_array #(.NUM_CHILDREN(8), .G_W(12), .ID_W(16), .ALLOW_EQUAL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid && !sel_dut), .in_ready(ir0),
        .children_v(children_v), .children_g(children_g), .children_id(children_id),
        .open_list(open_list), .close_list(close_list), .open_list_g_int(open_list_g_int),
        .out_valid(ov0), .out_ready(out_ready), .out_id(oid0), .out_g(og0), .out_last(ol0),
        .batch_done(bd0), .batch_count(bc0));

    child_validator_array #(.NUM_CHILDREN(8), .G_W(12), .ID_W(16), .ALLOW_EQUAL(1'b1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid && sel_dut), .in_ready(ir1),
        .children_v(children_v), .children_g(children_g), .children_id(children_id),
        .open_list(open_list), .close_list(close_list), .open_list_g_int(open_list_g_int),
        .out_valid(ov1), .out_ready(out_ready), .out_id(oid1), .out_g(og1), .out_last(ol1),
        .batch_done(bd1), .batch_count(bc1));

    assign in_ready = sel_dut ? ir1 : ir0;
    assign out_valid = sel_dut ? ov1 : ov0;
    assign out_last = sel_dut ? ol1 : ol0;
    assign batch_done = sel_dut ? bd1 : bd0;
    assign out_id = sel_dut ? oid1 : oid0;
    assign out_g = sel_dut ? og1 : og0;
    assign batch_count = sel_dut ? bc1 : bc0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int k, input bit v, input bit op, input bit cl,
                            input int g, input int og, input int id);
        children_v[k] = v;
        open_list[k] = op;
        close_list[k] = cl;
        children_g[k*12 +: 12] = 12'(g);
        open_list_g_int[k*12 +: 12] = 12'(og);
        children_id[k*16 +: 16] = 16'(id);
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 8; k++) set_slot(k, 1'b0, 1'b0, 1'b0, 0, 0, 16'h100 + k);
    endtask

    // Offers the current inputs as one batch and follows it to retirement, checking every cycle.
    task automatic run_batch(input bit which, input bit rand_stall, input int hold_first, input string nm);
        int q_id[$];
        int q_g[$];
        int n, j, held, stalls;
        bit rdy;
        for (int k = 0; k < 8; k++) begin
            int g, og;
            g = int'(children_g[k*12 +: 12]);
            og = int'(open_list_g_int[k*12 +: 12]);
            if (children_v[k] && !close_list[k] && (!open_list[k] || g < og || (which && g == og))) begin
                q_id.push_back(int'(children_id[k*16 +: 16]));
                q_g.push_back(g);
            end
        end
        n = q_id.size();
        sel_dut = which;
        out_ready = 1'b0;
        #0;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL %s idle in_ready got %b want 1", nm, in_ready); end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL %s eval out_valid/in_ready got %b/%b want 0/0", nm, out_valid, in_ready);
        end
        tick();
        tests++;
        if (batch_count !== 4'(n)) begin fails++; $display("FAIL %s batch_count got %0d want %0d", nm, batch_count, n); end
        j = 0;
        held = 0;
        stalls = 0;
        while (j < n) begin
            tests++;
            if (out_valid !== 1'b1 || out_id !== 16'(q_id[j]) || out_g !== 12'(q_g[j]) ||
                out_last !== (j == n - 1) || batch_done !== 1'b0) begin
                fails++;
                $display("FAIL %s item%0d got v=%b id=%h g=%h last=%b done=%b want v=1 id=%h g=%h last=%b done=0",
                         nm, j, out_valid, out_id, out_g, out_last, batch_done, 16'(q_id[j]), 12'(q_g[j]), j == n - 1);
            end
            if (j == 0 && held < hold_first) begin
                rdy = 1'b0;
                held++;
            end else if (rand_stall && stalls < 3) rdy = ($urandom_range(0, 2) != 0);
            else rdy = 1'b1;
            stalls = rdy ? 0 : stalls + 1;
            out_ready = rdy;
            tick();
            if (rdy) j++;
        end
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || batch_done !== 1'b1 || in_ready !== 1'b1) begin
            fails++; $display("FAIL %s retire v/done/ready got %b/%b/%b want 0/1/1", nm, out_valid, batch_done, in_ready);
        end
        tick();
        tests++;
        if (batch_done !== 1'b0 || batch_count !== 4'(n)) begin
            fails++; $display("FAIL %s after done/count got %b/%0d want 0/%0d", nm, batch_done, batch_count, n);
        end
    endtask

    task automatic test_reset();
        sel_dut = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if (ov0 !== 0 || ol0 !== 0 || bd0 !== 0 || bc0 !== 0 || oid0 !== 0 || og0 !== 0) begin
            fails++; $display("FAIL reset outputs got v=%b l=%b d=%b c=%0d id=%h g=%h want all 0", ov0, ol0, bd0, bc0, oid0, og0);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (ir0 !== 1'b1 || ir1 !== 1'b1) begin fails++; $display("FAIL reset in_ready got %b%b want 11", ir0, ir1); end
    endtask

    task automatic test_full_batch();
        clear_inputs();
        for (int k = 0; k < 8; k++) set_slot(k, 1'b1, 1'b0, 1'b0, 10 * k + 1, 0, 16'hA000 + k);
        run_batch(1'b0, 1'b0, 0, "full");
    endtask

    task automatic test_allow_equal();
        clear_inputs();
        set_slot(1, 1'b1, 1'b0, 1'b0, 7, 0, 16'h0011);
        set_slot(3, 1'b1, 1'b1, 1'b0, 5, 5, 16'h0033);
        run_batch(1'b0, 1'b0, 0, "eq_reject");
        run_batch(1'b1, 1'b0, 0, "eq_accept");
    endtask

    task automatic test_empty();
        clear_inputs();
        set_slot(0, 1'b1, 1'b0, 1'b1, 1, 0, 16'h0001);
        set_slot(7, 1'b1, 1'b0, 1'b1, 2, 0, 16'h0007);
        run_batch(1'b0, 1'b0, 0, "empty");
    endtask

    task automatic test_backpressure();
        clear_inputs();
        set_slot(2, 1'b1, 1'b0, 1'b0, 12'h222, 0, 16'hB002);
        set_slot(5, 1'b1, 1'b0, 1'b0, 12'h555, 0, 16'hB005);
        run_batch(1'b0, 1'b0, 3, "stall");
    endtask

    task automatic test_unsigned();
        clear_inputs();
        set_slot(0, 1'b1, 1'b1, 1'b0, 12'hFFF, 12'h000, 16'hC000);
        set_slot(1, 1'b1, 1'b1, 1'b0, 12'h000, 12'hFFF, 16'hC001);
        run_batch(1'b0, 1'b0, 0, "unsigned");
        run_batch(1'b1, 1'b0, 0, "unsigned_eq");
    endtask

    task automatic test_mid_reset();
        clear_inputs();
        for (int k = 0; k < 4; k++) set_slot(k, 1'b1, 1'b0, 1'b0, k + 1, 0, 16'hD000 + k);
        sel_dut = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_id !== 16'hD000) begin
            fails++; $display("FAIL midrst first got v=%b id=%h want 1/d000", out_valid, out_id);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || batch_done !== 1'b0) begin
            fails++; $display("FAIL midrst during got v=%b done=%b want 0/0", out_valid, batch_done);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || batch_done !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL midrst after got v=%b done=%b rdy=%b want 0/0/1", out_valid, batch_done, in_ready);
        end
        run_batch(1'b0, 1'b0, 0, "midrst_next");
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < 8; k++)
                set_slot(k, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                         $urandom_range(0, 15), $urandom_range(0, 15), int'($urandom_range(0, 65535)));
            run_batch(1'($urandom), 1'b1, 0, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_inputs();
        test_reset();
        test_full_batch();
        test_allow_equal();
        test_empty();
        test_backpressure();
        test_unsigned();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/child_validator_array.md
CHILD_VALIDATOR_ARRAY -- requirements
Module: child_validator_array

Parameters
REQ-001 SHALL provide NUM_CHILDREN, default 8: number of child slots evaluated per expanded node (range 1..16).
REQ-002 SHALL provide G_W, default 12: width of the g-cost fields.
REQ-003 SHALL provide ID_W, default 16: width of the child node index.
REQ-004 SHALL provide ALLOW_EQUAL, default 0: when 1, a child whose g equals the open-list g is also accepted.

Interface
REQ-005 SHALL have one clock, `clock`, input, 1 bit; all state changes on its rising edge.
REQ-006 SHALL have `reset`, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have `in_valid`, input, 1 bit: the batch on the input ports is valid.
REQ-008 SHALL have `in_ready`, output, 1 bit: the block accepts a batch this cycle.
REQ-009 SHALL have `children_v`, input, NUM_CHILDREN bits: per-slot child-exists flag.
REQ-010 SHALL have `children_g`, input, NUM_CHILDREN*G_W bits: per-slot child g, slot k at bits [k*G_W +: G_W].
REQ-011 SHALL have `children_id`, input, NUM_CHILDREN*ID_W bits: per-slot child node index.
REQ-012 SHALL have `open_list`, input, NUM_CHILDREN bits: the child is already in the open list.
REQ-013 SHALL have `close_list`, input, NUM_CHILDREN bits: the child is already in the closed list.
REQ-014 SHALL have `open_list_g_int`, input, NUM_CHILDREN*G_W bits: g stored in the open list for each child.
REQ-015 SHALL have `out_valid`, output, 1 bit: a validated child is presented.
REQ-016 SHALL have `out_ready`, input, 1 bit: the consumer accepts.
REQ-017 SHALL have `out_id` (ID_W bits) and `out_g` (G_W bits), both outputs: the presented child.
REQ-018 SHALL have `out_last`, output, 1 bit: the presented child is the final one of the batch.
REQ-019 SHALL have `batch_done`, output, 1 bit: one-cycle pulse when a batch has fully retired.
REQ-020 SHALL have `batch_count`, output, $clog2(NUM_CHILDREN+1) bits: number of children emitted for the last batch.

Function
REQ-021 SHALL implement FSM states IDLE, EVAL and EMIT; `in_ready` = 1 only in IDLE.
REQ-022 SHALL, on in_valid && in_ready, register all input vectors and go to EVAL.
REQ-023 SHALL, in EVAL, compute registered mask[k] = children_v[k] & ~close_list[k] & (~open_list[k] | g[k] < og[k]) using unsigned compare, with <= in place of < when ALLOW_EQUAL=1.
REQ-024 SHALL, in EVAL, load batch_count with popcount(mask) and go to EMIT if mask != 0, else to IDLE with batch_done pulsed.
REQ-025 SHALL, in EMIT, drive out_valid=1 together with out_id/out_g of the lowest-index set mask bit; out_last=1 when exactly one bit remains set.
REQ-026 SHALL, on out_valid && out_ready, clear that mask bit; if it was the last bit, go to IDLE and pulse batch_done in the following cycle.
REQ-027 SHALL hold out_id, out_g and out_last stable while out_valid && !out_ready.
REQ-028 SHALL keep out_valid=0 outside EMIT.
REQ-029 SHALL make first out_valid latency 2 cycles after acceptance: accept at edge N, EVAL during cycle N+1, out_valid during cycle N+2.
REQ-030 SHALL give a back-to-back batch a minimum spacing of emitted count + 2 cycles.
REQ-031 SHALL ignore in_valid while not in IDLE; the producer holds its inputs.
REQ-032 SHALL keep batch_count valid from EVAL until the next EVAL.

Reset
REQ-033 SHALL, on reset, take the FSM to IDLE, clear the mask and all captured registers, and drive in_ready=1 in the cycle after reset deasserts.
REQ-034 SHALL hold out_valid, out_last, batch_done, batch_count, out_id and out_g at 0 during reset.
REQ-035 SHALL, on reset mid-EMIT, abandon the batch with no batch_done pulse.

Verification
REQ-036 SHALL cover: N=8, children_v=8'hFF, close=0, open=0, out_ready=1 -> ids slot0..7 on 8 consecutive cycles, out_last on slot7, batch_count=8, batch_done one cycle later.
REQ-037 SHALL cover: slot3 open with g=5, og=5, ALLOW_EQUAL=0 -> slot3 rejected; with ALLOW_EQUAL=1 -> slot3 emitted.
REQ-038 SHALL cover: children_v=8'h81, close_list=8'h81 -> no out_valid, batch_done in cycle N+2, batch_count=0, in_ready=1 at N+2.
REQ-039 SHALL cover: mask=8'h24, out_ready low for 3 cycles -> slot2 held stable, then slot2, then slot5 with out_last=1.
REQ-040 SHALL cover: reset asserted after the first of 4 transfers -> out_valid=0 the next cycle, no batch_done, the new batch processed normally.
REQ-041 SHALL cover: g=12'hFFF vs og=12'h000, open=1 -> rejected (unsigned compare).
